// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the stream FIFO family.
package fifo_pkg;

  localparam int STATUS_CNT_W = 32;

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    almostFull;
    logic                    almostEmpty;
    logic                    overflow;
  } fifo_status_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful where the pointers say so.
module fifo_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with flush, threshold flags and sticky overflow.
// Capacity is DEPTH in both output modes; OUT_REG=1 adds one cycle of head latency.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter int WIDTH         = 32,
  parameter int OUT_REG       = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  localparam int CW           = count_width(DEPTH),
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_flush,
  input  logic [WIDTH-1:0] IN_data,
  input  logic             IN_valid,
  output logic             OUT_ready,
  input  logic             IN_ready,
  output logic             OUT_valid,
  output logic [WIDTH-1:0] OUT_data,
  output logic [CW-1:0]    OUT_count,
  output logic             OUT_almostFull,
  output logic             OUT_almostEmpty,
  output logic             OUT_overflow
);

  fifo_status_t            status_q, status_d;
  logic                    ready_q;
  logic                    head_vld;
  logic [WIDTH-1:0]        head_dat, ram_rdata;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push, pop, ram_we, rd_adv;
  logic [STATUS_CNT_W-1:0] cnt_n;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign push = IN_valid && ready_q && !IN_flush;
  assign pop  = head_vld && IN_ready && !IN_flush;

  always_comb begin
    cnt_n = status_q.count;
    if (IN_flush)          cnt_n = '0;
    else if (push && !pop) cnt_n = status_q.count + STATUS_CNT_W'(1);
    else if (pop && !push) cnt_n = status_q.count - STATUS_CNT_W'(1);
  end

  always_comb begin
    status_d             = status_q;
    status_d.count       = cnt_n;
    status_d.almostFull  = (cnt_n >= STATUS_CNT_W'(AFULL_THRESH));
    status_d.almostEmpty = (cnt_n <= STATUS_CNT_W'(AEMPTY_THRESH));
    status_d.overflow    = !IN_flush && (status_q.overflow || (IN_valid && !ready_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '{count: '0, almostFull: 1'b0, almostEmpty: 1'b1, overflow: 1'b0};
      ready_q  <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      status_q <= status_d;
      // Registered ready: a full FIFO refuses a push even if it pops that cycle.
      ready_q  <= (cnt_n != STATUS_CNT_W'(DEPTH));
      if (IN_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_adv) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (IN_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (OUT_REG == 0) begin : g_direct
    logic vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= (cnt_n != '0);
    end

    assign head_vld = vld_q;
    // Masked so the idle head reads as zero rather than stale storage.
    assign head_dat = vld_q ? ram_rdata : '0;
    assign ram_we   = push;
    assign rd_adv   = pop;
  end else begin : g_oreg
    logic                    ov_q;
    logic [WIDTH-1:0]        od_q;
    logic [STATUS_CNT_W-1:0] mem_cnt;
    logic                    refill, mem_has, bypass;

    assign mem_cnt = status_q.count - STATUS_CNT_W'(ov_q);
    assign refill  = !ov_q || pop;
    assign mem_has = (mem_cnt != '0);
    // Storage empty while the flop drains: the new word skips the RAM.
    assign bypass  = pop && push && !mem_has;
    assign ram_we  = push && !bypass;
    assign rd_adv  = refill && mem_has && !IN_flush;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov_q <= 1'b0;
        od_q <= '0;
      end else if (IN_flush) begin
        ov_q <= 1'b0;
      end else if (refill) begin
        if (mem_has) begin
          ov_q <= 1'b1;
          od_q <= ram_rdata;
        end else if (bypass) begin
          ov_q <= 1'b1;
          od_q <= IN_data;
        end else begin
          ov_q <= 1'b0;
        end
      end
    end

    assign head_vld = ov_q;
    assign head_dat = od_q;
  end

  assign OUT_ready       = ready_q;
  assign OUT_valid       = head_vld;
  assign OUT_data        = head_dat;
  assign OUT_count       = status_q.count[CW-1:0];
  assign OUT_almostFull  = status_q.almostFull;
  assign OUT_almostEmpty = status_q.almostEmpty;
  assign OUT_overflow    = status_q.overflow;

endmodule

// File: tb/tb_stream_fifo.sv
// Four FIFOs (DEPTH 5/6 x OUT_REG 0/1) share stimulus; each is checked against a queue model.
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready = 1'b0;

  logic        o_rdy [4];
  logic        o_vld [4];
  logic [31:0] o_dat [4];
  logic [2:0]  o_cnt [4];
  logic        o_af  [4];
  logic        o_ae  [4];
  logic        o_ovf [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    stream_fifo #(.DEPTH(5 + g / 2), .WIDTH(32), .OUT_REG(g % 2)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .IN_flush        (in_flush),
      .IN_data         (in_data),
      .IN_valid        (in_valid),
      .OUT_ready       (o_rdy[g]),
      .IN_ready        (in_ready),
      .OUT_valid       (o_vld[g]),
      .OUT_data        (o_dat[g]),
      .OUT_count       (o_cnt[g]),
      .OUT_almostFull  (o_af[g]),
      .OUT_almostEmpty (o_ae[g]),
      .OUT_overflow    (o_ovf[g])
    );
  end

  // Reference model: an unbounded list per FIFO plus the size before the last edge.
  logic [31:0] mdat [4][1024];
  int          mhead [4];
  int          mtail [4];
  int          mprev [4];
  logic        movf  [4];

  function automatic int dep(input int k);
    return 5 + k / 2;
  endfunction

  function automatic int msize(input int k);
    return mtail[k] - mhead[k];
  endfunction

  // A word entering an empty OUT_REG FIFO becomes visible one edge later.
  function automatic logic mvalid(input int k);
    if (k % 2 == 0) return msize(k) > 0;
    return (msize(k) > 0) && (mprev[k] > 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mhead[k] = 0; mtail[k] = 0; mprev[k] = 0; movf[k] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h, want %h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_model(input int k);
    int sz;
    sz = msize(k);
    chk("valid", k, 32'(o_vld[k]), 32'(mvalid(k)));
    if (mvalid(k)) chk("data", k, o_dat[k], mdat[k][mhead[k] % 1024]);
    chk("count", k, 32'(o_cnt[k]), sz);
    chk("ready", k, 32'(o_rdy[k]), 32'(sz != dep(k)));
    chk("afull", k, 32'(o_af[k]), 32'(sz >= dep(k) - 4));
    chk("aempty", k, 32'(o_ae[k]), 32'(sz <= 4));
    chk("overflow", k, 32'(o_ovf[k]), 32'(movf[k]));
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, k, 32'(o_vld[k]), 0);
      chk({tag, "_data"}, k, o_dat[k], 0);
      chk({tag, "_count"}, k, 32'(o_cnt[k]), 0);
      chk({tag, "_ready"}, k, 32'(o_rdy[k]), 1);
      chk({tag, "_afull"}, k, 32'(o_af[k]), 0);
      chk({tag, "_aempty"}, k, 32'(o_ae[k]), 1);
      chk({tag, "_overflow"}, k, 32'(o_ovf[k]), 0);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic pu [4];
    logic po [4];
    logic rj [4];
    in_valid = v; in_data = d; in_ready = r; in_flush = f;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_model(k);
      rj[k] = v && (msize(k) == dep(k));
      pu[k] = v && !rj[k] && !f;
      po[k] = mvalid(k) && r && !f;
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      mprev[k] = msize(k);
      if (f) begin
        mhead[k] = 0; mtail[k] = 0; movf[k] = 1'b0;
      end else begin
        if (rj[k]) movf[k] = 1'b1;
        if (po[k]) mhead[k]++;
        if (pu[k]) begin
          mdat[k][mtail[k] % 1024] = d;
          mtail[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    int          cnt;
    logic        rdy, af, ae, ovf, vld;
    logic [31:0] dat;
  } vec_t;

  vec_t tbl [11];
  int   seq;

  initial begin
    // Expected state of the DEPTH=5, OUT_REG=0 FIFO after each row's edge.
    tbl[0]  = '{1'b1, 32'hA0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0};
    tbl[1]  = '{1'b1, 32'hA1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0};
    tbl[2]  = '{1'b1, 32'hA2, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0};
    tbl[3]  = '{1'b1, 32'hA3, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA0};
    tbl[4]  = '{1'b1, 32'hA4, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0};
    tbl[5]  = '{1'b1, 32'hA5, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0};
    tbl[6]  = '{1'b1, 32'hA6, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1};
    tbl[7]  = '{1'b0, 32'h00, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA2};
    tbl[8]  = '{1'b0, 32'h00, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA3};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA4};
    tbl[10] = '{1'b0, 32'h00, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00};

    model_reset();
    #1 rst = 1'b1;
    #2 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow, push+pop while full, drain.
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk("tbl_count", 0, 32'(o_cnt[0]), tbl[i].cnt);
      chk("tbl_ready", 0, 32'(o_rdy[0]), 32'(tbl[i].rdy));
      chk("tbl_afull", 0, 32'(o_af[0]), 32'(tbl[i].af));
      chk("tbl_aempty", 0, 32'(o_ae[0]), 32'(tbl[i].ae));
      chk("tbl_overflow", 0, 32'(o_ovf[0]), 32'(tbl[i].ovf));
      chk("tbl_valid", 0, 32'(o_vld[0]), 32'(tbl[i].vld));
      if (tbl[i].vld) chk("tbl_data", 0, o_dat[0], tbl[i].dat);
    end

    // Flush with 3 words stored and a simultaneous push.
    cycle(1'b1, 32'hB0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB1, 1'b0, 1'b0);
    cycle(1'b1, 32'hB2, 1'b0, 1'b0);
    cycle(1'b1, 32'hEE, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("flush_count", k, 32'(o_cnt[k]), 0);
      chk("flush_valid", k, 32'(o_vld[k]), 0);
      chk("flush_overflow", k, 32'(o_ovf[k]), 0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Push-to-valid latency and order.
    cycle(1'b1, 32'h11, 1'b1, 1'b0);
    chk("lat_valid_oreg0", 0, 32'(o_vld[0]), 1);
    chk("lat_data_oreg0", 0, o_dat[0], 32'h11);
    chk("lat_valid_oreg1_early", 1, 32'(o_vld[1]), 0);
    cycle(1'b1, 32'h22, 1'b1, 1'b0);
    chk("lat_valid_oreg1", 1, 32'(o_vld[1]), 1);
    chk("lat_data_oreg1", 1, o_dat[1], 32'h11);
    chk("lat_data_oreg0_2nd", 0, o_dat[0], 32'h22);
    cycle(1'b1, 32'h33, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Head stays put while the consumer stalls.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) chk("stall_data", k, o_dat[k], 32'hC0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic: fill-biased, then drain-biased, with rare flushes.
    seq = 32'h1000;
    for (int i = 0; i < 1200; i++) begin
      logic v, r, f;
      if ((i / 150) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 199) == 0);
      cycle(v, 32'(seq), r, f);
      seq++;
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 32'hDD;
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous stream FIFO, the next generation of the basic valid/ready FIFO. It adds producer backpressure, selectable output registering, occupancy and threshold flags, synchronous flush, and sticky overflow detection. It sits between any two valid/ready stages in the same clock domain, for example decode→issue queues and memory request buffers.

## Interface
- DEPTH, 128: entries held, ≥2, any value (need not be a power of 2)
- WIDTH, 32: data bits per entry
- OUT_REG, 0: 0 = head read straight from storage; 1 = head held in an output flop (+1 cycle latency)
- AFULL_THRESH, DEPTH-4: OUT_almostFull when count ≥ this
- AEMPTY_THRESH, 4: OUT_almostEmpty when count ≤ this
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- IN_flush  in  1  synchronous clear of all contents
- IN_data  in  WIDTH  push data
- IN_valid  in  1  push request
- OUT_ready  out  1  FIFO can accept a push this cycle
- IN_ready  in  1  consumer accepts head this cycle
- OUT_valid  out  1  head entry valid
- OUT_data  out  WIDTH  head entry
- OUT_count  out  $clog2(DEPTH+1)  entries held, including the output flop when OUT_REG=1
- OUT_almostFull, OUT_almostEmpty  out  1  threshold flags
- OUT_overflow  out  1  sticky: push attempted while OUT_ready=0

## Operation
- Push accepted when IN_valid && OUT_ready. Pop accepted when OUT_valid && IN_ready.
- Capacity is exactly DEPTH in both modes. OUT_ready = (count != DEPTH) and is registered: a full FIFO rejects a push even when a pop happens in the same cycle.
- Pointers wrap from DEPTH-1 to 0 by compare, not by bit truncation. Full and empty are derived from count, never from pointer equality.
- Count update: push only +1; pop only -1; both or neither: unchanged.
- FIFO order is strict. OUT_data is stable while OUT_valid && !IN_ready.
- OUT_REG=1: the output flop is refilled from storage on the cycle it is popped or empty. With simultaneous push and pop and storage empty, the pushed word goes directly to the output flop.
- Flush has priority over push and pop that cycle. It clears pointers, count, OUT_valid, and OUT_overflow; memory contents are not cleared. OUT_data is don't-care after flush.
- Overflow: IN_valid && !OUT_ready sets OUT_overflow. The data is dropped and state is unchanged. Cleared only by rst or IN_flush.
- A pop while empty cannot occur, because OUT_valid=0.
- Reset values: OUT_valid=0, OUT_data=0, OUT_count=0, OUT_ready=1, OUT_almostFull=0, OUT_almostEmpty=1, OUT_overflow=0, pointers 0.
- rst mid-operation: all state returns to reset values immediately (asynchronous). Any push in flight is lost.

## Timing
- All outputs are registered except OUT_data when OUT_REG=0 (combinational read of storage at rdPtr).
- Push→OUT_valid into an empty FIFO: 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1).
- Pop→next head visible: same cycle plus 1 in both modes, so back-to-back pops run at full rate.
- OUT_count and the flags reflect the pushes/pops of the previous edge.
- Throughput: 1 push and 1 pop per cycle sustained when neither full nor empty.

## Structure
- Shared package fifo_pkg holds `typedef struct packed {count, almostFull, almostEmpty, overflow} fifo_status_t` and the count-width helper function.
- One sub-module, fifo_ram: DEPTH×WIDTH storage, 1 write port, 1 asynchronous read port, no reset.
- Pointer and count logic and the OUT_REG output stage stay in stream_fifo. The output stage is a generate branch.

## Test plan
- Reset, then push 0x11,0x22,0x33 with IN_ready=1 → OUT_data 0x11,0x22,0x33 in order; OUT_valid first seen 1 cycle after push (OUT_REG=0) or 2 cycles (OUT_REG=1).
- DEPTH=5: push 5 words with IN_ready=0 → OUT_count=5, OUT_ready=0, OUT_almostFull=1. A 6th push → OUT_overflow=1, and draining returns exactly the first 5 words.
- DEPTH=5, full: push and pop in the same cycle → pop accepted, push rejected, OUT_count=4, OUT_overflow=1.
- DEPTH=6 (not a power of 2): stream 20 words with random IN_valid/IN_ready → all 20 words out in order, with pointer wrap exercised 3 times.
- Hold IN_ready=0 while OUT_valid=1 for 4 cycles → OUT_data is unchanged every cycle.
- With 3 words stored, assert IN_flush together with a push → OUT_count=0, OUT_valid=0, OUT_overflow=0 next cycle, and the pushed word is discarded. Assert rst mid-burst → all outputs at reset values the same cycle.
